// File: rtl/rate_limit_sched.sv
`default_nettype none
// ============================================================================
// Module  : rate_limit_sched
// Brief   : Token-bucket round-robin scheduler for one rate-limited egress slot.
// Revision: 1.0
// ============================================================================
module rate_limit_sched #(
  parameter int R          = 4,
  parameter int CW         = 5,
  parameter int DEF_PERIOD = 15,
  parameter int DEF_INC    = 13,
  parameter int DEF_MAX    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [R-1:0]  req,
  input  logic          out_ready,
  output logic [R-1:0]  gnt,
  input  logic          cfg_vld,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_inc,
  input  logic [CW-1:0] cfg_max,
  output logic          cfg_err_r,
  output logic [CW-1:0] credit_r,
  output logic          running_r
);

  localparam int c_PW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [0:0] {
    c_OFF = 1'b0,
    c_RUN = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [c_PW-1:0] r_ptr;
  logic [CW-1:0]   r_period;
  logic [CW-1:0]   r_inc;
  logic [CW-1:0]   r_max;

  logic            w_run;
  logic            w_cfg_ok;
  logic            w_cfg_err;
  logic            w_g;
  logic            w_found;
  logic [c_PW-1:0] w_win_idx;
  logic [c_PW-1:0] w_ptr_nxt;
  logic            w_refill;
  logic [CW:0]     w_sum;
  logic [CW-1:0]   w_credit_nxt;

  function automatic logic [c_PW-1:0] wrap_idx(input logic [c_PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= R) s = s - R;
    return c_PW'(s);
  endfunction

  assign w_run     = (r_state == c_RUN);
  assign running_r = w_run;

  // A write on the OFF->RUN edge still counts as an OFF write.
  assign w_cfg_ok  = cfg_vld && (r_state == c_OFF) && (cfg_period != '0) && (cfg_max != '0);
  assign w_cfg_err = cfg_vld && !w_cfg_ok;

  assign w_g = w_run && (|req) && out_ready && (credit_r != '0);

  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int i = 0; i < R; i++) begin
      if (!w_found && req[wrap_idx(r_ptr, i)]) begin
        w_found   = 1'b1;
        w_win_idx = wrap_idx(r_ptr, i);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (w_g) gnt[w_win_idx] = 1'b1;
  end

  assign w_ptr_nxt = (w_win_idx == c_PW'(R - 1)) ? '0 : w_win_idx + 1'b1;

  assign w_refill = (r_cnt == r_period - 1'b1);

  // Grant and refill are netted in CW+1 bits before saturating at max.
  assign w_sum = {1'b0, credit_r} - {{CW{1'b0}}, w_g}
               + (w_refill ? {1'b0, r_inc} : {(CW+1){1'b0}});
  assign w_credit_nxt = (w_sum > {1'b0, r_max}) ? r_max : w_sum[CW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_OFF;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_OFF:   if (en)  w_state_nxt = c_RUN;
      c_RUN:   if (!en) w_state_nxt = c_OFF;
      default: w_state_nxt = c_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_r  <= CW'(DEF_MAX);
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_period  <= CW'(DEF_PERIOD);
      r_inc     <= CW'(DEF_INC);
      r_max     <= CW'(DEF_MAX);
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= w_cfg_err;
      if (w_cfg_ok) begin
        r_period <= cfg_period;
        r_inc    <= cfg_inc;
        r_max    <= cfg_max;
      end
      if (!w_run) begin
        if (en) begin
          credit_r <= w_cfg_ok ? cfg_max : r_max;
          r_cnt    <= '0;
        end
      end else begin
        r_cnt    <= w_refill ? '0 : r_cnt + 1'b1;
        credit_r <= w_credit_nxt;
        if (w_g) r_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rate_limit_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_rate_limit_sched
// Brief   : Scoreboard bench for rate_limit_sched with directed scenarios.
// Revision: 1.0
// ============================================================================
module tb_rate_limit_sched;

  localparam int R  = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [R-1:0]  req;
  logic          out_ready;
  logic [R-1:0]  gnt;
  logic          cfg_vld;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_inc;
  logic [CW-1:0] cfg_max;
  logic          cfg_err_r;
  logic [CW-1:0] credit_r;
  logic          running_r;

  rate_limit_sched #(
    .R(R), .CW(CW), .DEF_PERIOD(15), .DEF_INC(13), .DEF_MAX(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
    .gnt(gnt), .cfg_vld(cfg_vld), .cfg_period(cfg_period), .cfg_inc(cfg_inc),
    .cfg_max(cfg_max), .cfg_err_r(cfg_err_r), .credit_r(credit_r),
    .running_r(running_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           c;
    logic [R-1:0] g;
    int           ph;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   errors = 0;
  int   checks = 0;
  int   phase  = 0;

  // Every grant the DUT shows is matched against the oldest expected grant.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && gnt !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: cyc=%0d got gnt=%b required none", cyc, gnt);
      end else begin
        m_e = sb.pop_front();
        if (m_e.c != cyc || m_e.g !== gnt) begin
          errors++;
          $display("FAIL grant ph%0d: got gnt=%b at cyc=%0d required gnt=%b at cyc=%0d",
                   m_e.ph, gnt, cyc, m_e.g, m_e.c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req_v);
    end
  endtask

  task automatic expect_gnt(input int c, input logic [R-1:0] g);
    exp_t e;
    e.c  = c;
    e.g  = g;
    e.ph = phase;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(output int base);
    en   = 1'b1;
    base = cyc + 1;
  endtask

  task automatic stop_run();
    req = '0;
    en  = 1'b0;
    tick(2);
    chk("running_after_stop", running_r, 0);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    en         = 1'b0;
    req        = '0;
    out_ready  = 1'b1;
    cfg_vld    = 1'b0;
    cfg_period = '0;
    cfg_inc    = '0;
    cfg_max    = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("reset_credit", credit_r, 16);
    chk("reset_running", running_r, 0);
    chk("reset_cfg_err", cfg_err_r, 0);
    chk("reset_gnt", gnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int n;

    // Defaults under full load: 29 back-to-back grants, then 13 per window.
    do_reset();
    phase = 1;
    n = 0;
    for (int k = 0; k <= 28; k++) begin
      expect_gnt(k, R'(1) << (n % R));
      n++;
    end
    for (int w = 0; w < 9; w++) begin
      for (int k = 0; k < 13; k++) begin
        expect_gnt(30 + 15 * w + k, R'(1) << (n % R));
        n++;
      end
    end
    req = 4'b1111;
    start_run(b);
    for (int i = 0; i < sb.size(); i++) sb[i].c = sb[i].c + b;
    at_cyc(b + 14);  chk("p1_credit_c14", credit_r, 2);
    at_cyc(b + 15);  chk("p1_credit_c15", credit_r, 14);
    at_cyc(b + 29);  chk("p1_credit_c29", credit_r, 0);
    at_cyc(b + 165); chk("p1_credit_c165", credit_r, 13);
    stop_run();

    // Round-robin order with all requesters, then with an alternating mask.
    do_reset();
    phase = 2;
    req = 4'b1111;
    start_run(b);
    for (int k = 0; k < 8; k++) expect_gnt(b + k, R'(1) << (k % R));
    expect_gnt(b + 8, 4'b0010);
    expect_gnt(b + 9, 4'b1000);
    expect_gnt(b + 10, 4'b0010);
    expect_gnt(b + 11, 4'b1000);
    at_cyc(b + 8);
    req = 4'b1010;
    at_cyc(b + 12);
    stop_run();

    // Backpressure keeps the bucket saturated; release drains it.
    do_reset();
    phase = 3;
    req = 4'b1111;
    out_ready = 1'b0;
    start_run(b);
    n = 0;
    for (int k = 40; k <= 73; k++) begin
      expect_gnt(b + k, R'(1) << (n % R));
      n++;
    end
    expect_gnt(b + 75, R'(1) << (n % R));
    at_cyc(b + 20); chk("p3_credit_c20", credit_r, 16);
    at_cyc(b + 39); chk("p3_credit_c39", credit_r, 16);
    at_cyc(b + 40);
    out_ready = 1'b1;
    at_cyc(b + 56); chk("p3_credit_c56", credit_r, 5);
    at_cyc(b + 74); chk("p3_credit_c74", credit_r, 0);
    at_cyc(b + 76);
    stop_run();

    // Reconfigured bucket: period 4, inc 1, max 2.
    do_reset();
    phase = 4;
    cfg_vld = 1'b1; cfg_period = 5'd4; cfg_inc = 5'd1; cfg_max = 5'd2;
    tick(1);
    cfg_vld = 1'b0;
    chk("p4_cfg_err", cfg_err_r, 0);
    chk("p4_credit_off", credit_r, 16);
    req = 4'b0001;
    start_run(b);
    expect_gnt(b + 0, 4'b0001);
    expect_gnt(b + 1, 4'b0001);
    expect_gnt(b + 4, 4'b0001);
    expect_gnt(b + 8, 4'b0001);
    expect_gnt(b + 12, 4'b0001);
    expect_gnt(b + 16, 4'b0001);
    at_cyc(b + 2); chk("p4_credit_c2", credit_r, 0);
    at_cyc(b + 20);
    stop_run();

    // Config on the enable edge is accepted; RUN and zero-field writes are rejected.
    do_reset();
    phase = 5;
    cfg_vld = 1'b1; cfg_period = 5'd6; cfg_inc = 5'd2; cfg_max = 5'd3;
    start_run(b);
    tick(1);
    cfg_vld = 1'b0;
    chk("p5_edge_cfg_err", cfg_err_r, 0);
    chk("p5_edge_credit", credit_r, 3);
    chk("p5_running", running_r, 1);
    cfg_vld = 1'b1; cfg_period = 5'd4; cfg_inc = 5'd1; cfg_max = 5'd2;
    tick(1);
    cfg_vld = 1'b0;
    chk("p5_run_cfg_err", cfg_err_r, 1);
    tick(1);
    chk("p5_run_cfg_err_clear", cfg_err_r, 0);
    en = 1'b0;
    tick(2);
    cfg_vld = 1'b1; cfg_period = 5'd0; cfg_inc = 5'd1; cfg_max = 5'd5;
    tick(1);
    cfg_vld = 1'b0;
    chk("p5_zero_period_err", cfg_err_r, 1);
    cfg_vld = 1'b1; cfg_period = 5'd4; cfg_inc = 5'd1; cfg_max = 5'd0;
    tick(1);
    cfg_vld = 1'b0;
    chk("p5_zero_max_err", cfg_err_r, 1);
    tick(1);
    chk("p5_err_clear", cfg_err_r, 0);
    start_run(b);
    tick(1);
    chk("p5_max_unchanged", credit_r, 3);
    stop_run();

    // Asynchronous reset mid-burst with credit 5 and pointer 2.
    do_reset();
    phase = 6;
    req = 4'b1000;
    start_run(b);
    expect_gnt(b, 4'b1000);
    for (int k = 0; k < 10; k++) expect_gnt(b + 1 + k, R'(1) << (k % R));
    at_cyc(b + 1);
    req = 4'b1111;
    at_cyc(b + 11);
    chk("p6_credit_pre_reset", credit_r, 5);
    chk("p6_gnt_pre_reset", gnt, 4);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("p6_gnt_in_reset", gnt, 0);
    chk("p6_credit_in_reset", credit_r, 16);
    chk("p6_running_in_reset", running_r, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("p6_running_after", running_r, 0);
    chk("p6_credit_after", credit_r, 16);
    start_run(b);
    expect_gnt(b, 4'b0001);
    expect_gnt(b + 1, 4'b0010);
    at_cyc(b + 2);
    stop_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
